// File: rtl/hv_ang_pkg.sv
// Shared types and constants for the HV analog trim driver.
package hv_ang_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LATCH,
    ST_SETTLE,
    ST_DONE
  } trim_state_t;

  localparam logic [7:0] TRIM_WR_EN = 8'h20;

endpackage

// File: rtl/hv_cyc_timer.sv
// Loadable down-counter; expire is the terminal-count (zero) compare.
module hv_cyc_timer #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Holds at zero rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/hv_ang_trim_drv.sv
// Sequences a trim-code update into the HV analog block: setup, latch strobe,
// settle, then a done pulse; test-mode drop aborts the sequence.
//
//   state  | meaning
//   IDLE   | waiting for an enabled write strobe
//   SETUP  | new codes driven, latch low (SETUP_CYC cycles)
//   LATCH  | o_ang_lat high (LAT_CYC cycles)
//   SETTLE | codes committed, analog settling (SETTLE_CYC cycles)
//   DONE   | one-cycle o_done, busy low
module hv_ang_trim_drv
  import hv_ang_pkg::*;
#(
  parameter int CLK_M      = 50,
  parameter int SETUP_CYC  = (101 * CLK_M + 999) / 1000,
  parameter int LAT_CYC    = (501 * CLK_M + 999) / 1000,
  parameter int SETTLE_CYC = (2001 * CLK_M + 999) / 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_reg_dvdt_tm,
  input  logic       i_trim_wr,
  input  logic [7:0] i_cap_trim_code,
  input  logic [5:0] i_cnt_del,
  output logic [3:0] o_off_vbn,
  output logic [3:0] o_on_vbn,
  output logic [5:0] o_cnt_del,
  output logic       o_ang_lat,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_wr_err,
  output logic       o_abort
);

  localparam int MAX_A   = (SETUP_CYC > LAT_CYC) ? SETUP_CYC : LAT_CYC;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Timer counts N-1 down to 0, so a phase spans exactly N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LAT_LD    = CNT_W'(LAT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  trim_state_t      state;
  logic             mode_ok;
  logic             tm_load;
  logic [CNT_W-1:0] tm_val;
  logic             tm_exp;
  logic [7:0]       cap_code;
  logic [5:0]       cap_del;
  logic [7:0]       com_code;
  logic [5:0]       com_del;

  assign mode_ok = (i_reg_dvdt_tm == TRIM_WR_EN);

  always_comb begin
    tm_load = 1'b0;
    tm_val  = '0;
    case (state)
      ST_IDLE: begin
        if (i_trim_wr && mode_ok) begin
          tm_load = 1'b1;
          tm_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (!mode_ok || tm_exp) tm_load = 1'b1;
        if (mode_ok) tm_val = LAT_LD;
      end
      ST_LATCH: begin
        if (!mode_ok || tm_exp) tm_load = 1'b1;
        if (mode_ok) tm_val = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (!mode_ok) tm_load = 1'b1;
      end
      default: ;
    endcase
  end

  hv_cyc_timer #(.W(CNT_W)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (tm_load),
    .load_val (tm_val),
    .expire   (tm_exp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cap_code  <= '0;
      cap_del   <= '0;
      com_code  <= '0;
      com_del   <= '0;
      o_off_vbn <= '0;
      o_on_vbn  <= '0;
      o_cnt_del <= '0;
      o_ang_lat <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_wr_err  <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_done   <= 1'b0;
      o_abort  <= 1'b0;
      o_wr_err <= i_trim_wr && !(state == ST_IDLE && mode_ok);
      case (state)
        ST_IDLE: begin
          if (i_trim_wr && mode_ok) begin
            state     <= ST_SETUP;
            cap_code  <= i_cap_trim_code;
            cap_del   <= i_cnt_del;
            o_off_vbn <= i_cap_trim_code[7:4];
            o_on_vbn  <= i_cap_trim_code[3:0];
            o_cnt_del <= i_cnt_del;
            o_busy    <= 1'b1;
          end
        end
        ST_SETUP, ST_LATCH: begin
          // Abort before commit: fall back to the last committed codes.
          if (!mode_ok) begin
            state     <= ST_IDLE;
            o_off_vbn <= com_code[7:4];
            o_on_vbn  <= com_code[3:0];
            o_cnt_del <= com_del;
            o_ang_lat <= 1'b0;
            o_busy    <= 1'b0;
            o_abort   <= 1'b1;
          end else if (tm_exp && state == ST_SETUP) begin
            state     <= ST_LATCH;
            o_ang_lat <= 1'b1;
          end else if (tm_exp) begin
            state     <= ST_SETTLE;
            o_ang_lat <= 1'b0;
            com_code  <= cap_code;
            com_del   <= cap_del;
          end
        end
        ST_SETTLE: begin
          if (!mode_ok) begin
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
            o_abort <= 1'b1;
          end else if (tm_exp) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_ang_trim_drv.sv
// Scenario-table bench for hv_ang_trim_drv (CLK_M=50) with an offset-based
// reference model feeding a per-cycle expectation queue.
module tb_hv_ang_trim_drv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mode;
  logic       wr;
  logic [7:0] code;
  logic [5:0] del_in;
  logic [3:0] o_off_vbn, o_on_vbn;
  logic [5:0] o_cnt_del;
  logic       o_ang_lat, o_busy, o_done, o_wr_err, o_abort;

  always #5 clk = ~clk;

  hv_ang_trim_drv #(.CLK_M(50)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_reg_dvdt_tm   (mode),
    .i_trim_wr       (wr),
    .i_cap_trim_code (code),
    .i_cnt_del       (del_in),
    .o_off_vbn       (o_off_vbn),
    .o_on_vbn        (o_on_vbn),
    .o_cnt_del       (o_cnt_del),
    .o_ang_lat       (o_ang_lat),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_wr_err        (o_wr_err),
    .o_abort         (o_abort)
  );

  typedef struct packed {
    logic [3:0] off;
    logic [3:0] on;
    logic [5:0] del;
    logic       lat;
    logic       busy;
    logic       done;
    logic       err;
    logic       abort;
  } obs_t;

  typedef struct {
    string      name;
    logic [7:0] mode;
    logic [7:0] code;
    logic [5:0] del;
    int         dist_off;
    int         wr2_off;
    int         rst_off;
    int         len;
  } scen_t;

  obs_t  expq[$];
  scen_t tbl[12];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  string cur_name = "reset";

  // Model: offset k = cycles since the accepted strobe; 1..6 setup,
  // 7..32 latch, 33..133 settle, 134 done.
  bit         m_act = 0;
  int         m_t0 = 0;
  logic [7:0] m_cap_code = '0, m_com_code = '0;
  logic [5:0] m_cap_del = '0, m_com_del = '0;
  obs_t       m_o = '0;

  function automatic obs_t dut_obs();
    obs_t o;
    o = {o_off_vbn, o_on_vbn, o_cnt_del, o_ang_lat, o_busy, o_done, o_wr_err, o_abort};
    return o;
  endfunction

  task automatic model_step();
    int k;
    bit ok;
    m_o.done  = 0;
    m_o.err   = 0;
    m_o.abort = 0;
    if (!rst_n) begin
      m_act = 0;
      m_o = '0;
      m_cap_code = '0; m_cap_del = '0;
      m_com_code = '0; m_com_del = '0;
    end else begin
      ok = (mode == 8'h20);
      if (m_act) begin
        k = cyc - m_t0;
        if (wr) m_o.err = 1;
        if (k >= 134) begin
          m_act = 0;
        end else if (!ok) begin
          m_act = 0;
          m_o.abort = 1;
          m_o.busy = 0;
          m_o.lat = 0;
          if (k <= 32) begin
            m_o.off = m_com_code[7:4];
            m_o.on  = m_com_code[3:0];
            m_o.del = m_com_del;
          end
        end else begin
          m_o.busy = (k + 1 <= 133);
          m_o.lat  = (k + 1 >= 7) && (k + 1 <= 32);
          m_o.done = (k + 1 == 134);
          if (k + 1 == 33) begin
            m_com_code = m_cap_code;
            m_com_del  = m_cap_del;
          end
        end
      end else if (wr && ok) begin
        m_act = 1;
        m_t0 = cyc;
        m_cap_code = code;
        m_cap_del = del_in;
        m_o.off = code[7:4];
        m_o.on  = code[3:0];
        m_o.del = del_in;
        m_o.busy = 1;
      end else if (wr) begin
        m_o.err = 1;
      end
    end
  endtask

  task automatic step();
    obs_t e, g;
    model_step();
    expq.push_back(m_o);
    @(posedge clk);
    #1;
    cyc++;
    e = expq.pop_front();
    g = dut_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %h want %h (off,on,del,lat,busy,done,err,abort)",
               cur_name, cyc, g, e);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int t, t_done, t_lat, n_lat, n_busy;

    tbl[0]  = '{"abort_latch",       8'h20, 8'hA5, 6'h2C,  10,  -1, -1,  14};
    tbl[1]  = '{"nominal",           8'h20, 8'hA5, 6'h2C,  -1,  -1, -1, 136};
    tbl[2]  = '{"wr_while_busy",     8'h20, 8'hA5, 6'h2C,  -1,  50, -1, 136};
    tbl[3]  = '{"wr_in_done",        8'h20, 8'h69, 6'h07,  -1, 134, -1, 137};
    tbl[4]  = '{"abort_settle",      8'h20, 8'h5A, 6'h11,  60,  -1, -1,  64};
    tbl[5]  = '{"abort_setup",       8'h20, 8'hC3, 6'h3F,   3,  -1, -1,   7};
    tbl[6]  = '{"abort_last_setup",  8'h20, 8'hC3, 6'h3F,   6,  -1, -1,   9};
    tbl[7]  = '{"abort_last_latch",  8'h20, 8'hC3, 6'h3F,  32,  -1, -1,  36};
    tbl[8]  = '{"abort_first_settle",8'h20, 8'h81, 6'h22,  33,  -1, -1,  37};
    tbl[9]  = '{"abort_last_settle", 8'h20, 8'hA5, 6'h2C, 133,  -1, -1, 137};
    tbl[10] = '{"bad_mode",          8'h10, 8'h77, 6'h01,  -1,  -1, -1,   5};
    tbl[11] = '{"rst_mid",           8'h20, 8'h96, 6'h2A,  -1,  -1, 20,  24};

    rst_n = 0; mode = 8'h20; wr = 0; code = '0; del_in = '0;
    #1;
    chk("reset_outputs", int'(dut_obs()), 0);
    repeat (2) step();
    rst_n = 1;
    repeat (2) step();

    for (int s = 0; s < 12; s++) begin
      cur_name = tbl[s].name;
      for (int i = 0; i <= tbl[s].len; i++) begin
        wr     = (i == 0) || (i == tbl[s].wr2_off);
        code   = (i == 0) ? tbl[s].code : ~tbl[s].code;
        del_in = (i == 0) ? tbl[s].del : ~tbl[s].del;
        mode   = (tbl[s].dist_off >= 0 && i >= tbl[s].dist_off) ? 8'h00 : tbl[s].mode;
        if (i == tbl[s].rst_off) begin
          rst_n = 0;
          #1;
          chk("rst_immediate", int'(dut_obs()), 0);
        end else begin
          rst_n = 1;
        end
        step();
      end
      rst_n = 1; mode = 8'h20; wr = 0;
      repeat (3) step();
    end

    // Directed timing count after the mid-sequence reset.
    cur_name = "directed";
    wr = 1; code = 8'h5A; del_in = 6'h13;
    step();
    wr = 0;
    chk("dir_off_t1", int'(o_off_vbn), 5);
    chk("dir_on_t1", int'(o_on_vbn), 10);
    chk("dir_del_t1", int'(o_cnt_del), 19);
    t = 1; t_done = -1; t_lat = -1; n_lat = 0; n_busy = 0;
    while (t_done < 0 && t < 300) begin
      if (o_ang_lat) begin
        n_lat++;
        if (t_lat < 0) t_lat = t;
      end
      if (o_busy) n_busy++;
      if (o_done) t_done = t;
      else begin
        step();
        t++;
      end
    end
    chk("dir_done_latency", t_done, 134);
    chk("dir_first_latch", t_lat, 7);
    chk("dir_latch_width", n_lat, 26);
    chk("dir_busy_cycles", n_busy, 133);
    chk("dir_busy_at_done", int'(o_busy), 0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
